// File: rtl/pulse_param_loader.sv
// rtl/pulse_param_loader.sv - UART parameter-frame loader with shadow/live register banks
//
// Receives 8N1 bytes on rxd, parses frames SYNC, ADDR, D3, D2, D1, D0, CHK
// (CHK = ADDR^D3^D2^D1^D0, payload MSB first), writes the payload into a
// shadow bank and copies the whole shadow bank to the live outputs on a
// commit frame (address 0F).
// Optional feature macro: PARAM_ERRCNT_EN (adds err_count, address 0E clears it).
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   rxd              UART serial input, idle high, asynchronous to clk
//   per              live period (32 bit)
//   p1wid..nut_d     live pulse timing values (16 bit)
//   nut_w            live nutation width (8 bit)
//   pr_att           live attenuator code (7 bit)
//   cp, bl           live mode (0 = CW, 1 = pulsed) and block enable
//   frame_ok         one-cycle pulse, frame accepted
//   frame_err        one-cycle pulse, frame dropped
//   busy             parser outside IDLE
//   err_count        saturating frame_err counter (PARAM_ERRCNT_EN only)
module pulse_param_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          TIMEOUT_CLKS = 20000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [15:0] p1wid2,
    output logic [15:0] del2,
    output logic [15:0] p2wid2,
    output logic [15:0] p1st2,
    output logic [7:0]  nut_w,
    output logic [15:0] nut_d,
    output logic [6:0]  pr_att,
    output logic        cp,
    output logic        bl,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy
`ifdef PARAM_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2;
        logic [7:0]  nut_w;
        logic [15:0] nut_d;
        logic [6:0]  pr_att;
        logic        cp;
        logic        bl;
    } params_t;

    localparam params_t RST_PARAMS = '{per: 32'd10000, p1wid: 16'd20, del: 16'd200,
        p2wid: 16'd40, p1wid2: 16'd0, del2: 16'd0, p2wid2: 16'd0, p1st2: 16'd0,
        nut_w: 8'd0, nut_d: 16'd100, pr_att: 7'd0, cp: 1'b1, bl: 1'b0};

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ferr_q, rx_ferr_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                // Edge detect so a line held low after a bad stop bit does not restart
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == 16'(HALF_BIT - 1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'(CLKS_PER_BIT - 1)) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- Frame parser ----------------
    typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_CHK} p_state_t;

    p_state_t    p_state_q, p_state_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] tmo_q, tmo_d;
    logic        ok_d, err_d, wr_en, commit_en, addr_mapped;
    params_t     shadow_q, shadow_d, live_q;
`ifdef PARAM_ERRCNT_EN
    logic        clr_en;
    logic [7:0]  err_cnt_q;
    assign addr_mapped = (addr_q <= 8'h0C) || (addr_q == 8'h0F) || (addr_q == 8'h0E);
`else
    assign addr_mapped = (addr_q <= 8'h0C) || (addr_q == 8'h0F);
`endif

    always_comb begin
        p_state_d = p_state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bcnt_d    = bcnt_q;
        chk_d     = chk_q;
        tmo_d     = (p_state_q != P_IDLE) ? tmo_q + 32'd1 : 32'd0;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        commit_en = 1'b0;
`ifdef PARAM_ERRCNT_EN
        clr_en    = 1'b0;
`endif
        if (rx_ferr_q) begin
            p_state_d = P_IDLE;
            err_d     = 1'b1;
        end else if (rx_valid_q) begin
            tmo_d = 32'd0;
            case (p_state_q)
                P_IDLE: if (rx_shift_q == SYNC_BYTE) p_state_d = P_ADDR;
                P_ADDR: begin
                    addr_d    = rx_shift_q;
                    chk_d     = rx_shift_q;
                    bcnt_d    = 2'd0;
                    p_state_d = P_DATA;
                end
                P_DATA: begin
                    data_d = {data_q[23:0], rx_shift_q};
                    chk_d  = chk_q ^ rx_shift_q;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) p_state_d = P_CHK;
                end
                P_CHK: begin
                    p_state_d = P_IDLE;
                    if ((rx_shift_q == chk_q) && addr_mapped) begin
                        ok_d = 1'b1;
                        if (addr_q == 8'h0F) commit_en = 1'b1;
`ifdef PARAM_ERRCNT_EN
                        else if (addr_q == 8'h0E) clr_en = 1'b1;
`endif
                        else wr_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
        end else if ((p_state_q != P_IDLE) && (tmo_q == 32'(TIMEOUT_CLKS - 1))) begin
            p_state_d = P_IDLE;
            err_d     = 1'b1;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            case (addr_q[3:0])
                4'h0: shadow_d.per    = data_q;
                4'h1: shadow_d.p1wid  = data_q[15:0];
                4'h2: shadow_d.del    = data_q[15:0];
                4'h3: shadow_d.p2wid  = data_q[15:0];
                4'h4: shadow_d.p1wid2 = data_q[15:0];
                4'h5: shadow_d.del2   = data_q[15:0];
                4'h6: shadow_d.p2wid2 = data_q[15:0];
                4'h7: shadow_d.p1st2  = data_q[15:0];
                4'h8: shadow_d.nut_w  = data_q[7:0];
                4'h9: shadow_d.nut_d  = data_q[15:0];
                4'hA: shadow_d.pr_att = data_q[6:0];
                4'hB: shadow_d.cp     = data_q[0];
                4'hC: shadow_d.bl     = data_q[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state_q <= P_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            bcnt_q    <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            shadow_q  <= RST_PARAMS;
            live_q    <= RST_PARAMS;
`ifdef PARAM_ERRCNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            p_state_q <= p_state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bcnt_q    <= bcnt_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            shadow_q  <= shadow_d;
            if (commit_en) live_q <= shadow_q;
`ifdef PARAM_ERRCNT_EN
            if (clr_en) err_cnt_q <= '0;
            else if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
`endif
        end
    end

`ifdef PARAM_ERRCNT_EN
    assign err_count = err_cnt_q;
`endif
    assign busy   = (p_state_q != P_IDLE);
    assign per    = live_q.per;
    assign p1wid  = live_q.p1wid;
    assign del    = live_q.del;
    assign p2wid  = live_q.p2wid;
    assign p1wid2 = live_q.p1wid2;
    assign del2   = live_q.del2;
    assign p2wid2 = live_q.p2wid2;
    assign p1st2  = live_q.p1st2;
    assign nut_w  = live_q.nut_w;
    assign nut_d  = live_q.nut_d;
    assign pr_att = live_q.pr_att;
    assign cp     = live_q.cp;
    assign bl     = live_q.bl;

endmodule

// File: tb/tb_pulse_param_loader.sv
// tb/tb_pulse_param_loader.sv - self-checking bench for pulse_param_loader
module tb_pulse_param_loader;
    localparam int CPB = 16;
    localparam int TMO = 1000;
`ifdef PARAM_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif
    localparam logic [31:0] RST_VAL [13] = '{32'd10000, 32'd20, 32'd200, 32'd40, 32'd0, 32'd0,
                                             32'd0, 32'd0, 32'd0, 32'd100, 32'd0, 32'd1, 32'd0};

    logic clk = 1'b0;
    logic rst, rxd;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d;
    logic [7:0]  nut_w;
    logic [6:0]  pr_att;
    logic        cp, bl, frame_ok, frame_err, busy;
`ifdef PARAM_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    pulse_param_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .p1wid2(p1wid2), .del2(del2), .p2wid2(p2wid2), .p1st2(p1st2), .nut_w(nut_w),
        .nut_d(nut_d), .pr_att(pr_att), .cp(cp), .bl(bl), .frame_ok(frame_ok),
        .frame_err(frame_err), .busy(busy)
`ifdef PARAM_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int ok_seen = 0, err_seen = 0, ok_exp = 0, err_exp = 0, errcnt_m = 0;
    logic [31:0] shadow_m [13];
    logic [31:0] live_m [13];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok && frame_err) check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
        end
    end

    function automatic logic [31:0] mask_of(input int i);
        case (i)
            0: return 32'hFFFF_FFFF;
            8: return 32'h0000_00FF;
            10: return 32'h0000_007F;
            11, 12: return 32'h0000_0001;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] live_obs(input int i);
        case (i)
            0: return per;
            1: return 32'(p1wid);
            2: return 32'(del);
            3: return 32'(p2wid);
            4: return 32'(p1wid2);
            5: return 32'(del2);
            6: return 32'(p2wid2);
            7: return 32'(p1st2);
            8: return 32'(nut_w);
            9: return 32'(nut_d);
            10: return 32'(pr_att);
            11: return 32'(cp);
            12: return 32'(bl);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            shadow_m[i] = RST_VAL[i];
            live_m[i]   = RST_VAL[i];
        end
        errcnt_m = 0;
    endtask

    task automatic model_err();
        err_exp++;
        if (errcnt_m < 255) errcnt_m++;
    endtask

    task automatic model_frame(input logic [7:0] a, input logic [31:0] d, input bit good);
        bit mapped;
        mapped = (a <= 8'h0C) || (a == 8'h0F) || (ERRCNT && a == 8'h0E);
        if (good && mapped) begin
            ok_exp++;
            if (a == 8'h0F) for (int i = 0; i < 13; i++) live_m[i] = shadow_m[i];
            else if (a == 8'h0E) errcnt_m = 0;
            else shadow_m[a] = d & mask_of(int'(a));
        end else begin
            model_err();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit corrupt);
        logic [7:0] chk;
        chk = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ (corrupt ? 8'h5A : 8'h00);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(d[31:24], 1'b1);
        send_byte(d[23:16], 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(chk, 1'b1);
        model_frame(a, d, !corrupt);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, " frame_ok count"}, 32'(ok_seen), 32'(ok_exp));
        check({tag, " frame_err count"}, 32'(err_seen), 32'(err_exp));
        check({tag, " busy"}, 32'(busy), 32'd0);
`ifdef PARAM_ERRCNT_EN
        check({tag, " err_count"}, 32'(err_count), 32'(errcnt_m));
`endif
    endtask

    task automatic check_live(input string tag);
        for (int i = 0; i < 13; i++)
            check($sformatf("%s live[%0d]", tag, i), live_obs(i), live_m[i]);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        bit          bad;
        int          k;
        rst = 1'b1;
        rxd = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check_counts("reset");
        check_live("reset");

        send_frame(8'h01, 32'd100, 1'b0);
        check_counts("p1wid write");
        check_live("p1wid before commit");
        send_frame(8'h0F, 32'd0, 1'b0);
        check_counts("commit1");
        check_live("commit1");

        send_frame(8'h00, 32'h0001_86A0, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0);
        check_counts("per 100000");
        check_live("per 100000");

        send_frame(8'h02, 32'h0000_0010, 1'b1);
        check_counts("bad chk");
        send_frame(8'h0F, 32'd0, 1'b0);
        check_live("del kept");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TMO - 100) @(negedge clk);
        check("timeout busy held", 32'(busy), 32'd1);
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        model_err();
        repeat (2) @(negedge clk);
        check_counts("timeout");
        send_frame(8'h03, 32'h0000_1234, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0);
        check_counts("after timeout");
        check_live("after timeout");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h3C, 1'b0);
        model_err();
        repeat (4) @(negedge clk);
        check_counts("framing err");
        send_frame(8'h0B, 32'h0000_0002, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0);
        check_counts("after framing err");
        check_live("after framing err");

        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_counts("glitch");

        for (int n = 0; n < 12; n++) begin
            k = int'($urandom_range(0, 16));
            a = (k == 16) ? 8'(32'h10 + $urandom_range(0, 239)) : 8'(k);
            d = $urandom;
            bad = ($urandom_range(0, 3) == 0);
            send_frame(a, d, bad);
            check_counts($sformatf("rand%0d a=%0h", n, a));
            if (n % 4 == 3) begin
                send_frame(8'h0F, $urandom, 1'b0);
                check_live($sformatf("rand commit%0d", n));
            end
        end

        for (int n = 0; n < 3; n++) send_frame(8'h05, $urandom, 1'b1);
        check_counts("three bad");
        send_frame(8'h0E, 32'd0, 1'b0);
        check_counts("addr 0E");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_live("mid-frame reset");
        check("mid-frame reset busy", 32'(busy), 32'd0);
        send_frame(8'h0F, 32'd0, 1'b0);
        check_counts("post reset commit");
        check_live("post reset commit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
